instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage between the program counter and the instruction decoder.
- Each cycle of operation: samples the current PC, issues a read to instruction memory over a req/ack handshake, and latches the returned instruction into an instruction register (IR).
- Presents the IR to the decoder with a valid/ready handshake, and pulses pc_inc so the PC advances exactly once per captured instruction.
- A flush input (taken jump) discards any in-flight or held instruction.

Parameters:
AW, 16, PC / instruction-memory address width
IW, 16, instruction word width
CW, 16, width of delivered-instruction counter

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
pc_in  in  AW  current PC value from the program counter
flush  in  1  taken-jump; PC is being reloaded, discard current fetch
pc_inc  out  1  one-cycle pulse: PC must advance by 1
mem_req  out  1  instruction memory read request
mem_addr  out  AW  read address, registered
mem_ack  in  1  memory returns mem_rdata this cycle
mem_rdata  in  IW  instruction word, valid when mem_ack=1
ir_out  out  IW  instruction register to decoder
ir_pc  out  AW  address the instruction in ir_out was fetched from
ir_valid  out  1  ir_out holds an undelivered instruction
ir_ready  in  1  decoder accepts ir_out when ir_valid=1
fetch_cnt  out  CW  count of instructions delivered to decoder

Behaviour:
- Reset: Reset=1 at a rising edge forces the following, regardless of state or in-flight request:
  - state<=ISSUE, mem_req<=0, mem_addr<=0, pc_inc<=0
  - ir_valid<=0, ir_out<=0, ir_pc<=0, fetch_cnt<=0, drop<=0
  - Memory must tolerate an abandoned request on Reset.
- All outputs are registered; no combinational path from any input to any output.
- States: ISSUE, REQ, HOLD.
- ISSUE (mem_req=0):
  - mem_addr<=pc_in; next REQ.
  - Exists so that pc_in is sampled one cycle after any pc_inc or jump load has settled.
  - flush in ISSUE: no effect beyond the normal transition; pc_in is resampled that edge.
- REQ:
  - mem_req=1 and mem_addr held stable until mem_ack. Request is never withdrawn before ack, except by Reset.
  - flush while in REQ without ack: set drop<=1, remain REQ.
  - On mem_ack with drop=0 and flush=0: ir_out<=mem_rdata, ir_pc<=mem_addr, ir_valid<=1, pc_inc<=1 (next cycle only), mem_req<=0; next HOLD.
  - On mem_ack with drop=1 or flush=1: discard data, ir_valid stays 0, no pc_inc, drop<=0, mem_req<=0; next ISSUE.
- HOLD:
  - ir_valid=1; ir_out and ir_pc stable.
  - pc_inc high only in the first HOLD cycle.
  - ir_valid&ir_ready (and flush=0): ir_valid<=0, fetch_cnt<=fetch_cnt+1 (wraps modulo 2^CW); next ISSUE.
  - flush=1 (with or without ready): ir_valid<=0, fetch_cnt unchanged, instruction considered not delivered; next ISSUE.
  - flush in the first HOLD cycle does not cancel the already-registered pc_inc pulse; the PC gives jump load priority over increment.
- Latency and throughput:
  - Zero-wait memory (ack in first REQ cycle) with ready tied high: ISSUE, REQ, HOLD = one instruction per 3 cycles.
  - Each memory wait cycle adds 1; each cycle of ready low adds 1.
- mem_addr wraps naturally from 2^AW-1 (PC owns the wrap; this block only samples).
- Exactly one pc_inc pulse per accepted mem_ack; never on dropped fetches.

Test Plan:
- Reset mid-REQ (mem_addr=5, no ack), Reset 1 cycle -> next cycle mem_req=0, ir_valid=0, fetch_cnt=0, state ISSUE; ISSUE then samples pc_in.
- Zero-wait fetch, pc_in=3, mem_rdata=16'hA5A5, ready=1 -> mem_addr=3; ir_valid=1 and pc_inc=1 in same cycle with ir_out=A5A5, ir_pc=3; next cycle ir_valid=0, fetch_cnt=1; new mem_addr=4 two cycles later.
- Memory 3 wait states, pc_in=7 -> mem_req held 4 cycles with mem_addr=7 constant; exactly one pc_inc; ir_pc=7.
- Decoder back-pressure: ir_ready=0 for 5 cycles after capture -> ir_valid and ir_out stable 6 cycles; pc_inc high only first cycle; fetch_cnt increments once on acceptance.
- flush in REQ before ack, then ack with 16'hDEAD -> ir_valid never rises, no pc_inc; ISSUE samples new pc_in=3; next delivered instruction has ir_pc=3.
- flush coincident with handshake in HOLD -> ir_valid<=0, fetch_cnt unchanged; run 2^CW deliveries with CW=4 -> fetch_cnt wraps 15->0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage between the program counter and the decoder.
// Each instruction takes three steps. The block samples the PC, reads the
// instruction from memory over a req/ack handshake, and holds the word in the
// IR until the decoder takes it over a valid/ready handshake. It pulses pc_inc
// once for every instruction it captures. A flush (taken jump) throws away any
// fetch still in flight and any instruction still held.
//
// Ports:
//   Clk, Reset      clock; synchronous active-high reset
//   pc_in           current PC from the program counter
//   flush           taken jump: discard the current fetch / held instruction
//   pc_inc          one-cycle pulse, PC advances by one
//   mem_req/addr    instruction memory read request and registered address
//   mem_ack/rdata   memory response; rdata valid when ack=1
//   ir_out/ir_pc    instruction register and the address it came from
//   ir_valid/ready  handshake to the decoder
//   fetch_cnt       number of instructions delivered (wraps)
module instr_fetch_unit #(
  parameter int unsigned AW = 16,
  parameter int unsigned IW = 16,
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] pc_in,
  input  logic          flush,
  output logic          pc_inc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] ir_out,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [CW-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          pc_inc_q, pc_inc_d;
  logic [IW-1:0] ir_out_q, ir_out_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic          ir_valid_q, ir_valid_d;
  logic [CW-1:0] fetch_cnt_q, fetch_cnt_d;
  // A flush arrived while a request was outstanding. The request cannot be
  // withdrawn, so the data that returns for it must be thrown away.
  logic          drop_q, drop_d;

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ISSUE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      pc_inc_q    <= 1'b0;
      ir_out_q    <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      pc_inc_q    <= pc_inc_d;
      ir_out_q    <= ir_out_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      drop_q      <= drop_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    pc_inc_d    = 1'b0;          // pulse: high only in the cycle after capture
    ir_out_d    = ir_out_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    drop_d      = drop_q;

    unique case (state_q)
      // Sample the PC one cycle after any increment or jump load has settled
      ISSUE: begin
        mem_addr_d = pc_in;
        mem_req_d  = 1'b1;
        state_d    = REQ;
      end

      // Hold the request and address stable until memory acknowledges
      REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (drop_q || flush) begin
            state_d = ISSUE;
          end else begin
            ir_out_d   = mem_rdata;
            ir_pc_d    = mem_addr_q;
            ir_valid_d = 1'b1;
            pc_inc_d   = 1'b1;
            state_d    = HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      // Present the IR until it is accepted or flushed. A flush wins over
      // ready, so the instruction is then not counted as delivered.
      HOLD: begin
        if (flush) begin
          ir_valid_d = 1'b0;
          state_d    = ISSUE;
        end else if (ir_ready) begin
          ir_valid_d  = 1'b0;
          fetch_cnt_d = fetch_cnt_q + CW'(1);
          state_d     = ISSUE;
        end
      end

      default: begin
        state_d    = ISSUE;
        mem_req_d  = 1'b0;
        ir_valid_d = 1'b0;
        drop_d     = 1'b0;
      end
    endcase
  end

  assign pc_inc    = pc_inc_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ir_out    = ir_out_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule
